// File: rtl/memory_request_responder_pkg.sv
// Shared types for the memory request responder: word type, RAM status and
// responder FSM states.
package memory_request_responder_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFETCH = 3'd1,
        DRD    = 3'd2,
        DWR    = 3'd3,
        RESP   = 3'd4
    } resp_state_t;

endpackage

// File: rtl/memory_request_responder_counter.sv
// Saturating wait counter for one RAM access; expired_c flags the last
// permitted cycle (count == WAIT_LIMIT-1).
module access_timeout_counter
    import memory_request_responder_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_LIMIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = (count == LAST);

endmodule

// File: rtl/memory_request_responder.sv
// Arbitrates instruction fetch and data requests onto one RAM port, returns
// one-cycle hits with load data, and tracks sticky halt and error flags.
module memory_request_responder
    import memory_request_responder_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 64,
    parameter word_t       ERR_WORD   = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        halted,
    output logic        memerr,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    resp_state_t state, state_nxt;
    ramstate_t   ram_st;
    logic        in_access, done, fail, expired_c;
    logic        halt_pend, halt_pend_nxt, halted_nxt, memerr_nxt;
    logic        ram_ren_nxt, ram_wen_nxt, ihit_nxt, dhit_nxt;
    word_t       iload_nxt, dload_nxt, addr_nxt, store_nxt;

    assign ram_st    = ramstate_t'(ramstate);
    assign in_access = (state == IFETCH) || (state == DRD) || (state == DWR);
    assign done      = in_access && (state_nxt == RESP);
    assign fail      = (ram_st != ACCESS);

    access_timeout_counter #(.WAIT_LIMIT(WAIT_LIMIT)) u_timeout (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (~in_access),
        .en        (in_access),
        .expired_c (expired_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Halt (live, pending or sticky) blocks grants; data outranks fetch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!(halted || halt || halt_pend)) begin
                    if (dWEN)      state_nxt = DWR;
                    else if (dREN) state_nxt = DRD;
                    else if (iREN) state_nxt = IFETCH;
                end
            end
            IFETCH, DRD, DWR: begin
                if ((ram_st == ACCESS) || (ram_st == ERROR) || expired_c) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state.
    always_comb begin
        ihit_nxt      = 1'b0;
        dhit_nxt      = 1'b0;
        iload_nxt     = iload;
        dload_nxt     = dload;
        addr_nxt      = ramaddr;
        store_nxt     = ramstore;
        halted_nxt    = halted;
        halt_pend_nxt = halt_pend;
        memerr_nxt    = memerr;
        ram_ren_nxt   = (state_nxt == IFETCH) || (state_nxt == DRD);
        ram_wen_nxt   = (state_nxt == DWR);
        if (state == IDLE) begin
            if (halted || halt || halt_pend) halted_nxt = 1'b1;
            if (state_nxt == IFETCH) addr_nxt = iaddr;
            if ((state_nxt == DRD) || (state_nxt == DWR)) begin
                addr_nxt  = daddr;
                store_nxt = dstore;
            end
            if ((state_nxt == DWR) && dREN) memerr_nxt = 1'b1;
        end else if (halt) begin
            halt_pend_nxt = 1'b1;
        end
        if (done) begin
            ihit_nxt = (state == IFETCH);
            dhit_nxt = (state != IFETCH);
            if (fail) memerr_nxt = 1'b1;
            if (state == IFETCH) begin
                iload_nxt = fail ? ERR_WORD : ramload;
            end else if ((state == DRD) || fail) begin
                dload_nxt = fail ? ERR_WORD : ramload;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            iload     <= '0;
            dload     <= '0;
            halted    <= 1'b0;
            halt_pend <= 1'b0;
            memerr    <= 1'b0;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= '0;
            ramstore  <= '0;
        end else begin
            ihit      <= ihit_nxt;
            dhit      <= dhit_nxt;
            iload     <= iload_nxt;
            dload     <= dload_nxt;
            halted    <= halted_nxt;
            halt_pend <= halt_pend_nxt;
            memerr    <= memerr_nxt;
            ramREN    <= ram_ren_nxt;
            ramWEN    <= ram_wen_nxt;
            ramaddr   <= addr_nxt;
            ramstore  <= store_nxt;
        end
    end

endmodule

// File: tb/tb_memory_request_responder.sv
// Self-checking bench: directed vector table, hand-written halt/priority/reset
// sequences, and random transactions against a transaction-level model.
module tb_memory_request_responder;

    localparam int          WL     = 4;
    localparam logic [31:0] ERRW   = 32'hBAD1BAD1;
    localparam logic [1:0]  S_FREE = 2'd0;
    localparam logic [1:0]  S_BUSY = 2'd1;
    localparam logic [1:0]  S_ACC  = 2'd2;
    localparam logic [1:0]  S_ERR  = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN, halt;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        ihit, dhit, halted, memerr, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks = 0;
    int errors = 0;

    memory_request_responder #(.WAIT_LIMIT(WL), .ERR_WORD(ERRW)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .halt(halt),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .halted(halted), .memerr(memerr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // kind: 0 fetch, 1 read, 2 write, 3 read+write together
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rload;
        int          lat;
        bit          err;
        bit          drop;
        int          exp_hit;
        logic [31:0] exp_load;
        bit          exp_memerr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drop_reqs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hits"}, 32'({ihit, dhit}), 32'd0);
        chk({tag, "_en"}, 32'({ramREN, ramWEN}), 32'd0);
        chk({tag, "_flags"}, 32'({halted, memerr}), 32'd0);
        chk({tag, "_ramaddr"}, ramaddr, 32'd0);
        chk({tag, "_ramstore"}, ramstore, 32'd0);
        chk({tag, "_iload"}, iload, 32'd0);
        chk({tag, "_dload"}, dload, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; drop_reqs(); halt = 1'b0; ramstate = S_FREE; ramload = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b0;
    endtask

    // Issue one request at cycle 0, play RAM for it, check every cycle to the hit.
    task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rload, input int lat, input bit err, input bit drop,
                          input int exp_hit, input logic [31:0] exp_load, input bit exp_memerr);
        bit is_rd;
        is_rd = (kind == 0) || (kind == 1);
        @(negedge CLK);
        iREN = (kind == 0);
        dREN = (kind == 1) || (kind == 3);
        dWEN = (kind == 2) || (kind == 3);
        iaddr  = (kind == 0) ? addr : $urandom;
        daddr  = (kind != 0) ? addr : $urandom;
        dstore = data;
        ramstate = S_FREE;
        ramload  = $urandom;
        for (int c = 1; c <= exp_hit; c++) begin
            @(negedge CLK);
            if (c < exp_hit) begin
                chk("access_hits", 32'({ihit, dhit}), 32'd0);
                chk("access_en", 32'({ramREN, ramWEN}), is_rd ? 32'd2 : 32'd1);
                chk("access_addr", ramaddr, addr);
                if (!is_rd) chk("access_store", ramstore, data);
                ramstate = (c == lat) ? (err ? S_ERR : S_ACC) : S_BUSY;
                ramload  = (c == lat) ? rload : $urandom;
                if (drop && c == 1) drop_reqs();
            end else begin
                chk("resp_hits", 32'({ihit, dhit}), (kind == 0) ? 32'd2 : 32'd1);
                chk("resp_en", 32'({ramREN, ramWEN}), 32'd0);
                chk("resp_load", (kind == 0) ? iload : dload, exp_load);
                chk("resp_memerr", 32'(memerr), 32'(exp_memerr));
                drop_reqs();
                ramstate = S_FREE;
            end
        end
    endtask

    int          r_kind, r_lat, n;
    bit          r_err, r_drop, responds, failed;
    logic [31:0] r_addr, r_data, r_rload, m_iload, m_dload, exp_load;
    bit          m_memerr;

    initial begin
        RST = 1'b1; drop_reqs(); halt = 1'b0; ramstate = S_FREE;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;

        vecs[0] = '{0, 32'h40,  32'h0,        32'h8C220004, 3, 0, 0, 4, 32'h8C220004, 0};
        vecs[1] = '{1, 32'h200, 32'h0,        32'h12345678, 1, 0, 1, 2, 32'h12345678, 0};
        vecs[2] = '{2, 32'h100, 32'hDEADBEEF, 32'h0,        1, 0, 0, 2, 32'h12345678, 0};
        vecs[3] = '{1, 32'h300, 32'h0,        32'hCAFEF00D, 4, 0, 0, 5, 32'hCAFEF00D, 0};
        vecs[4] = '{1, 32'h304, 32'h0,        32'h0,        0, 0, 1, 5, ERRW,         1};
        vecs[5] = '{1, 32'h308, 32'h0,        32'h0,        1, 1, 0, 2, ERRW,         1};
        vecs[6] = '{0, 32'h44,  32'h0,        32'h00001111, 2, 0, 0, 3, 32'h00001111, 1};
        vecs[7] = '{3, 32'h80,  32'h55,       32'h0,        1, 0, 0, 2, ERRW,         1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].kind, vecs[i].addr, vecs[i].data, vecs[i].rload, vecs[i].lat,
                   vecs[i].err, vecs[i].drop, vecs[i].exp_hit, vecs[i].exp_load, vecs[i].exp_memerr);
        end
        chk("memerr_sticky", 32'(memerr), 32'd1);

        // Fetch and write together: write first, fetch after an idle cycle.
        do_reset();
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        @(negedge CLK);
        chk("prio_c1_en", 32'({ramREN, ramWEN}), 32'd1);
        chk("prio_c1_addr", ramaddr, 32'h100);
        chk("prio_c1_store", ramstore, 32'hDEADBEEF);
        ramstate = S_ACC;
        @(negedge CLK);
        chk("prio_c2_hits", 32'({ihit, dhit}), 32'd1);
        dWEN = 1'b0; ramstate = S_FREE;
        @(negedge CLK);
        chk("prio_c3_idle", 32'({ramREN, ramWEN, ihit, dhit}), 32'd0);
        @(negedge CLK);
        chk("prio_c4_en", 32'({ramREN, ramWEN}), 32'd2);
        chk("prio_c4_addr", ramaddr, 32'h80);
        ramstate = S_ACC; ramload = 32'h00000011;
        @(negedge CLK);
        chk("prio_c5_hits", 32'({ihit, dhit}), 32'd2);
        chk("prio_c5_iload", iload, 32'h00000011);
        ramstate = S_FREE;

        // Halt pulsed mid-fetch: fetch completes, then no further grants.
        @(negedge CLK);
        iREN = 1'b0;
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h60;
        @(negedge CLK);
        chk("halt_c1_ren", 32'(ramREN), 32'd1);
        halt = 1'b1; ramstate = S_BUSY;
        @(negedge CLK);
        halt = 1'b0;
        @(negedge CLK);
        ramstate = S_ACC; ramload = 32'h00000077;
        @(negedge CLK);
        chk("halt_c4_ihit", 32'(ihit), 32'd1);
        chk("halt_c4_iload", iload, 32'h00000077);
        chk("halt_c4_halted", 32'(halted), 32'd0);
        ramstate = S_FREE;
        @(negedge CLK);
        @(negedge CLK);
        chk("halt_c6_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("halted_no_grant", 32'({ramREN, ramWEN, ihit, dhit}), 32'd0);
        end
        chk("halted_sticky", 32'(halted), 32'd1);

        // Reset during a data read abandons it without a hit.
        do_reset();
        @(negedge CLK);
        dREN = 1'b1; daddr = 32'h500;
        @(negedge CLK);
        chk("rst_c1_ren", 32'(ramREN), 32'd1);
        ramstate = S_BUSY;
        @(negedge CLK);
        RST = 1'b1; dREN = 1'b0;
        @(negedge CLK);
        chk_all_zero("rst_mid");
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_after", 32'({ramREN, ihit, dhit}), 32'd0);
        ramstate = S_FREE;
        do_txn(1, 32'h504, 32'h0, 32'h0BADF00D, 2, 0, 0, 3, 32'h0BADF00D, 0);

        // Random transactions against the transaction-level model.
        do_reset();
        m_iload = '0; m_dload = '0; m_memerr = 1'b0;
        for (int t = 0; t < 200; t++) begin
            r_kind  = $urandom_range(0, 3);
            r_lat   = $urandom_range(0, WL + 2);
            r_err   = ($urandom_range(0, 5) == 0);
            r_drop  = $urandom_range(0, 1);
            r_addr  = $urandom;
            r_data  = $urandom;
            r_rload = $urandom;
            responds = (r_lat >= 1) && (r_lat <= WL);
            n        = responds ? r_lat : WL;
            failed   = !responds || r_err;
            if (r_kind == 0)      m_iload = failed ? ERRW : r_rload;
            else if (r_kind == 1) m_dload = failed ? ERRW : r_rload;
            else if (failed)      m_dload = ERRW;
            m_memerr = m_memerr || failed || (r_kind == 3);
            exp_load = (r_kind == 0) ? m_iload : m_dload;
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            do_txn(r_kind, r_addr, r_data, r_rload, r_lat, r_err, r_drop, n + 1, exp_load, m_memerr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_request_responder.md
Name: memory_request_responder

Overview:
- Memory-side responder for the control unit's request outputs (iREN, dREN, dWEN, halt).
- Arbitrates instruction-fetch and data requests onto the single RAM port and waits on RAM state.
- Returns a one-cycle ihit/dhit with load data, latches halt, and flags RAM errors and timeouts.
- Sits between the datapath/request logic and the RAM model.

Parameters:
- WAIT_LIMIT, 64: max cycles spent in an access state before the transaction is aborted (range 2..255).
- ERR_WORD, 32'hBAD1BAD1: load value returned on an aborted or errored transaction.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; one clock; reset is synchronous and active-high
- iREN  in  1  instruction read request, held until ihit
- iaddr  in  32  instruction word address
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit
- daddr  in  32  data address
- dstore  in  32  write data
- halt  in  1  halt from control unit
- ihit  out  1  one-cycle instruction completion pulse
- iload  out  32  fetched instruction, valid when ihit
- dhit  out  1  one-cycle data completion pulse
- dload  out  32  read data, valid when dhit
- halted  out  1  sticky; no further grants
- memerr  out  1  sticky; RAM ERROR, timeout or dREN&dWEN seen
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset values: all outputs 0; state IDLE; wait counter 0; address/data latches 0. Reset mid-transaction abandons it; no hit is issued.
- IDLE:
  - If halted, or halt asserted this cycle: set halted and stay in IDLE.
  - Else data has priority: dWEN -> DWR; else dREN -> DRD; else iREN -> IFETCH.
  - On grant, latch daddr/dstore (data) or iaddr (fetch) into internal registers.
  - dREN and dWEN both high: treat as write and set memerr.
- DRD, DWR, IFETCH:
  - Drive ramaddr and ramstore from the latches; ramREN=1 for DRD/IFETCH, ramWEN=1 for DWR.
  - Wait counter increments each cycle in the state.
  - ramstate==ACCESS: capture ramload (reads), go to RESP.
  - ramstate==ERROR: capture ERR_WORD, set memerr, go to RESP.
  - Counter reaches WAIT_LIMIT-1 without ACCESS/ERROR: same action as ERROR.
  - FREE/BUSY: stay.
- RESP: exactly one cycle.
  - Assert ihit (fetch) or dhit (data), never both; iload/dload hold the captured word.
  - ram enables are 0; counter clears; next state IDLE.
  - iload/dload keep their value until the next capture.
- Latency: the request is sampled in IDLE at cycle 0 and RAM is driven from cycle 1. If ACCESS arrives on cycle 1, hit asserts in cycle 2. A requester must see hit before issuing a new request.
- Hold rule: a request dropped mid-access is not cancelled; the transaction completes and still pulses hit.
- Simultaneous halt and request in IDLE: halt wins; nothing is granted.
- Halt asserted during an access: the access completes with hit, then the block enters halted.
- The block never issues back-to-back grants without passing through RESP then IDLE, so there is at least 1 idle cycle between transactions.
- halted and memerr clear only on RST.
- Addresses and data pass through unmodified; no alignment checking.

Decomposition:
- Shared package (alongside cpu_types_pkg):
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR).
  - resp_state_t enum (IDLE, IFETCH, DRD, DWR, RESP).
  - word_t is reused.
- One natural sub-module, access_timeout_counter: saturating wait counter with clear, enable and WAIT_LIMIT compare output.

Test Plan:
- Fetch: iREN=1, iaddr=0x40, RAM returns ACCESS on 3rd cycle with ramload=0x8C220004 -> ramREN=1 with ramaddr=0x40 for cycles 1-3; ihit=1 and iload=0x8C220004 in cycle 4 only; dhit=0 throughout.
- Priority: iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEADBEEF, immediate ACCESS -> DWR first with ramWEN=1 and ramstore=0xDEADBEEF; dhit in cycle 2; IFETCH granted in cycle 4 and ihit in cycle 5.
- Timeout: WAIT_LIMIT=4, dREN=1, ramstate held BUSY -> dhit after 4 access cycles; dload=0xBAD1BAD1; memerr=1 and stays 1.
- RAM error: dREN=1 with ramstate=ERROR -> dhit next cycle, dload=ERR_WORD, memerr=1.
- Halt: halt=1 during an in-flight fetch -> ihit still pulses, then halted=1; a subsequent iREN is never granted (ramREN stays 0 for 20 cycles).
- Reset: RST asserted during DRD -> next cycle all outputs are 0, no dhit, state IDLE; a new dREN completes normally.
